// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner for packed BCD values, with per-frame snapshot
// so a running counter upstream never tears a displayed frame.
module bcd_display_scanner #(
   parameter int N             = 4,
   parameter int PRESCALE      = 50000,
   parameter int BLANK_LEADING = 1
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [4*N-1:0] value,
   input  logic [N-1:0]   dp_mask,
   input  logic           blank,
   output logic [6:0]     seg_n,
   output logic           dp_n,
   output logic [N-1:0]   an_n,
   output logic           frame_start
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

   logic [PW-1:0]  pcnt;
   logic           tick;
   logic [IW-1:0]  idx;
   logic [IW-1:0]  next_idx;
   logic           frame_begin;
   logic [4*N-1:0] snap;
   logic [N-1:0]   dp_snap;
   logic [4*N-1:0] frame_data;
   logic [N-1:0]   frame_dp;
   logic [N-1:0]   lz_blank;
   logic           zero_run;
   logic [3:0]     nibble;
   logic           digit_dp;
   logic           digit_blank;
   logic [6:0]     seg_next;
   logic           dp_next;

   function automatic logic [6:0] decode_digit(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   assign tick        = (pcnt == PCNT_LAST);
   assign next_idx    = (idx == IDX_LAST) ? '0 : idx + 1'b1;
   assign frame_begin = (next_idx == '0);

   // Digit 0 decodes straight from the incoming bus on the edge that captures it.
   assign frame_data = frame_begin ? value : snap;
   assign frame_dp   = frame_begin ? dp_mask : dp_snap;

   always_comb begin
      zero_run = 1'b1;
      lz_blank = '0;
      for (int i = N - 1; i >= 0; i--) begin
         zero_run = zero_run & (frame_data[4*i +: 4] == 4'd0);
         if (i > 0 && BLANK_LEADING != 0)
            lz_blank[i] = zero_run;
      end
   end

   always_comb begin
      nibble      = '0;
      digit_dp    = 1'b0;
      digit_blank = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (next_idx == IW'(i)) begin
            nibble      = frame_data[4*i +: 4];
            digit_dp    = frame_dp[i];
            digit_blank = lz_blank[i];
         end
      end
   end

   always_comb begin
      seg_next = decode_digit(nibble);
      dp_next  = ~digit_dp;
      if (digit_blank)
         seg_next = 7'h7F;
      if (blank) begin
         seg_next = 7'h7F;
         dp_next  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         pcnt <= '0;
      else if (tick)
         pcnt <= '0;
      else
         pcnt <= pcnt + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx         <= IDX_LAST;
         snap        <= '0;
         dp_snap     <= '0;
         seg_n       <= 7'h7F;
         dp_n        <= 1'b1;
         an_n        <= '1;
         frame_start <= 1'b0;
      end else begin
         frame_start <= tick && frame_begin;
         if (tick) begin
            idx   <= next_idx;
            an_n  <= ~(N'(1) << next_idx);
            seg_n <= seg_next;
            dp_n  <= dp_next;
            if (frame_begin) begin
               snap    <= value;
               dp_snap <= dp_mask;
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner: three instances (default blanking, no blanking,
// PRESCALE=1) share inputs and are checked every cycle against an independent slot model.
module tb_bcd_display_scanner;

   localparam int          PRESC     [3] = '{4, 4, 1};
   localparam bit          BLANK_LEAD[3] = '{1'b1, 1'b0, 1'b1};
   localparam logic [12:0] DARK          = {4'hF, 7'h7F, 1'b1, 1'b0};

   logic        clk;
   logic        reset_n;
   logic [15:0] value;
   logic [3:0]  dp_mask;
   logic        blank;

   logic [6:0] seg_n       [3];
   logic       dp_n        [3];
   logic [3:0] an_n        [3];
   logic       frame_start [3];

   int compareCount  = 0;
   int mismatchCount = 0;

   logic [38:0] expQ[$];
   logic [12:0] held   [3];
   logic [15:0] snapV  [3];
   logic [3:0]  snapD  [3];
   int          edgeCount;

   bcd_display_scanner #(.N(4), .PRESCALE(4), .BLANK_LEADING(1)) dut (
      .clk(clk), .reset_n(reset_n), .value(value), .dp_mask(dp_mask), .blank(blank),
      .seg_n(seg_n[0]), .dp_n(dp_n[0]), .an_n(an_n[0]), .frame_start(frame_start[0]));

   bcd_display_scanner #(.N(4), .PRESCALE(4), .BLANK_LEADING(0)) dutNoBlank (
      .clk(clk), .reset_n(reset_n), .value(value), .dp_mask(dp_mask), .blank(blank),
      .seg_n(seg_n[1]), .dp_n(dp_n[1]), .an_n(an_n[1]), .frame_start(frame_start[1]));

   bcd_display_scanner #(.N(4), .PRESCALE(1), .BLANK_LEADING(1)) dutFast (
      .clk(clk), .reset_n(reset_n), .value(value), .dp_mask(dp_mask), .blank(blank),
      .seg_n(seg_n[2]), .dp_n(dp_n[2]), .an_n(an_n[2]), .frame_start(frame_start[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] segOf(input logic [3:0] nib);
      case (nib)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   // Expected {an_n, seg_n, dp_n} for digit d of a frame holding data/dpm.
   function automatic logic [11:0] expSlot(input logic [15:0] data, input logic [3:0] dpm,
                                           input logic blk, input int d, input bit lead);
      logic [15:0] upper;
      logic [6:0]  seg;
      logic        dp;
      logic [3:0]  an;
      upper = data >> (4 * d);
      seg   = segOf(upper[3:0]);
      if (lead && d > 0 && upper == 16'd0)
         seg = 7'h7F;
      dp = ~dpm[d];
      if (blk) begin
         seg = 7'h7F;
         dp  = 1'b1;
      end
      an = ~(4'b0001 << d);
      return {an, seg, dp};
   endfunction

   function automatic logic [15:0] bcdInc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
            else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] v, input logic [3:0] dpm, input logic b, input int cycles);
      value   = v;
      dp_mask = dpm;
      blank   = b;
      repeat (cycles) @(negedge clk);
   endtask

   // Model: slot timing derived from edges since reset release, one entry pushed per edge.
   always @(posedge clk) begin
      if (!reset_n) begin
         edgeCount = 0;
         for (int k = 0; k < 3; k++) begin
            held[k]  = DARK;
            snapV[k] = '0;
            snapD[k] = '0;
         end
      end else begin
         edgeCount++;
         for (int k = 0; k < 3; k++) begin
            held[k][0] = 1'b0;
            if (edgeCount % PRESC[k] == 0) begin
               int slotDigit;
               slotDigit = (edgeCount / PRESC[k] - 1) % 4;
               if (slotDigit == 0) begin
                  snapV[k]   = value;
                  snapD[k]   = dp_mask;
                  held[k][0] = 1'b1;
               end
               held[k][12:1] = expSlot(snapV[k], snapD[k], blank, slotDigit, BLANK_LEAD[k]);
            end
         end
      end
      expQ.push_back({held[0], held[1], held[2]});
   end

   always @(posedge clk) begin
      logic [38:0] e;
      #1;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("dut",        {3'b0, an_n[0], seg_n[0], dp_n[0], frame_start[0]}, {3'b0, e[38:26]});
         checkOutput("dutNoBlank", {3'b0, an_n[1], seg_n[1], dp_n[1], frame_start[1]}, {3'b0, e[25:13]});
         checkOutput("dutFast",    {3'b0, an_n[2], seg_n[2], dp_n[2], frame_start[2]}, {3'b0, e[12:0]});
      end
   end

   initial begin
      logic [15:0] cnt;
      reset_n = 1'b0;
      applyStimulus(16'h0123, 4'b0000, 1'b0, 3);
      reset_n = 1'b1;
      applyStimulus(16'h0123, 4'b0000, 1'b0, 6);

      reset_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++)
         checkOutput("resetDark", {3'b0, an_n[k], seg_n[k], dp_n[k], frame_start[k]}, {3'b0, DARK});
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      applyStimulus(16'h0123, 4'b0000, 1'b0, 40);
      applyStimulus(16'h0000, 4'b0100, 1'b0, 36);
      applyStimulus(16'h0A05, 4'b0000, 1'b0, 36);
      applyStimulus(16'h0123, 4'b0001, 1'b1, 12);
      applyStimulus(16'h0123, 4'b0001, 1'b0, 10);

      cnt = 16'h0990;
      repeat (320) begin
         applyStimulus(cnt, 4'($urandom), 1'b0, 1);
         cnt = bcdInc(cnt);
      end

      @(negedge clk);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
